wb_regfile_stage: RTL and testbench

- Consumer end of the MEM/WB pipeline register: the write-back stage plus the integer register file.
- Selects the write-back value from the latched load data, ALU result or link address, and commits it to a 32x32 register file.
- Serves the two ID-stage read ports (rs, rt) with same-cycle write-through bypass.
- Keeps a committed-write counter and a debug read port for the bench and board monitor.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/regfile_2r1w.sv | 80 ++++++++
 rtl/wb_regfile_stage.sv | 82 ++++++++
 tb/tb_wb_regfile_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline encodings and width defaults
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_LINK = 2'b10,
    WB_SEL_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - integer register file, one write port, rs/rt/debug reads
// Register 0 is hard-wired to zero; reads see the write being committed this cycle.
module regfile_2r1w
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] dbg_q;
  logic [DATA_W-1:0] dbg_d;
  logic              wr_en;

  assign wr_en = we && (waddr != ZERO_IDX);

  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              wen,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    if (addr == ZERO_IDX) begin
      return '0;
    end else if (wen && (addr == wa)) begin
      return wd;
    end else begin
      return stored;
    end
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    ra_data = '0;
    rb_data = '0;
    dbg_d   = '0;
    ra_data = read_port(ra_addr, wr_en, waddr, wdata, regs_q[ra_addr]);
    rb_data = read_port(rb_addr, wr_en, waddr, wdata, regs_q[rb_addr]);
    dbg_d   = read_port(dbg_addr, wr_en, waddr, wdata, regs_q[dbg_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      dbg_q <= '0;
    end else begin
      regs_q <= regs_d;
      dbg_q  <= dbg_d;
    end
  end

  assign dbg_data = dbg_q;

endmodule

// File: rtl/wb_regfile_stage.sv
// rtl/wb_regfile_stage.sv - write-back select, register file and committed-write counter
// Forwarding outputs (outWbData/outWbValid) are combinational from the MEM/WB inputs.
module wb_regfile_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inRegWrite,
  input  logic [1:0]        inMemtoReg,
  input  logic [ADDR_W-1:0] inWriteReg,
  input  logic [DATA_W-1:0] inAluLatch,
  input  logic [DATA_W-1:0] inLoadWordDividerMEM,
  input  logic [DATA_W-1:0] inPcPlus8,
  input  logic [ADDR_W-1:0] inRsAddr,
  input  logic [ADDR_W-1:0] inRtAddr,
  input  logic [ADDR_W-1:0] inDbgAddr,
  output logic [DATA_W-1:0] outRsData,
  output logic [DATA_W-1:0] outRtData,
  output logic [DATA_W-1:0] outDbgData,
  output logic [DATA_W-1:0] outWbData,
  output logic              outWbValid,
  output logic [CNT_W-1:0]  outWriteCount
);

  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic [CNT_W-1:0]  write_count_q;
  logic [CNT_W-1:0]  write_count_d;

  // Reserved select 11 (and an unknown select) falls back to the ALU result.
  always_comb begin
    wb_data = inAluLatch;
    case (inMemtoReg)
      WB_SEL_MEM:  wb_data = inLoadWordDividerMEM;
      WB_SEL_LINK: wb_data = inPcPlus8;
      default:     wb_data = inAluLatch;
    endcase
  end

  assign commit = inRegWrite && (inWriteReg != ADDR_W'(REG_ZERO));

  always_comb begin
    write_count_d = write_count_q;
    if (commit) begin
      write_count_d = write_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_count_q <= '0;
    end else begin
      write_count_q <= write_count_d;
    end
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .we       (inRegWrite),
    .waddr    (inWriteReg),
    .wdata    (wb_data),
    .ra_addr  (inRsAddr),
    .rb_addr  (inRtAddr),
    .dbg_addr (inDbgAddr),
    .ra_data  (outRsData),
    .rb_data  (outRtData),
    .dbg_data (outDbgData)
  );

  assign outWbData     = wb_data;
  assign outWbValid    = commit;
  assign outWriteCount = write_count_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// tb/tb_wb_regfile_stage.sv - self-checking bench with reference register model
module tb_wb_regfile_stage;

  localparam int CW = 4;

  logic        clk;
  logic        reset;
  logic        inRegWrite;
  logic [1:0]  inMemtoReg;
  logic [4:0]  inWriteReg;
  logic [31:0] inAluLatch;
  logic [31:0] inLoadWordDividerMEM;
  logic [31:0] inPcPlus8;
  logic [4:0]  inRsAddr;
  logic [4:0]  inRtAddr;
  logic [4:0]  inDbgAddr;
  logic [31:0] outRsData;
  logic [31:0] outRtData;
  logic [31:0] outDbgData;
  logic [31:0] outWbData;
  logic        outWbValid;
  logic [CW-1:0] outWriteCount;

  wb_regfile_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .inRegWrite           (inRegWrite),
    .inMemtoReg           (inMemtoReg),
    .inWriteReg           (inWriteReg),
    .inAluLatch           (inAluLatch),
    .inLoadWordDividerMEM (inLoadWordDividerMEM),
    .inPcPlus8            (inPcPlus8),
    .inRsAddr             (inRsAddr),
    .inRtAddr             (inRtAddr),
    .inDbgAddr            (inDbgAddr),
    .outRsData            (outRsData),
    .outRtData            (outRtData),
    .outDbgData           (outDbgData),
    .outWbData            (outWbData),
    .outWbValid           (outWbValid),
    .outWriteCount        (outWriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;
  logic [31:0]  m_regs [32];
  int unsigned  m_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_wb(input logic [1:0] sel, input logic [31:0] alu,
                                      input logic [31:0] ld, input logic [31:0] pc);
    if (sel == 2'd1) return ld;
    if (sel == 2'd2) return pc;
    return alu;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit wr,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (wr && a == wa) return wd;
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_count = 0;
  endtask

  task automatic drive(input logic we, input logic [1:0] sel, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    inRegWrite = we; inMemtoReg = sel; inWriteReg = wa;
    inAluLatch = alu; inLoadWordDividerMEM = ld; inPcPlus8 = pc;
    inRsAddr = rs; inRtAddr = rt; inDbgAddr = dbg;
  endtask

  // Checks combinational outputs before the edge, then state after it.
  task automatic cycle(input bit chk_wb);
    bit          wr;
    logic [31:0] wd;
    logic [31:0] dbg_exp;
    #1;
    wr = (inRegWrite === 1'b1) && (inWriteReg != 5'd0);
    wd = m_wb(inMemtoReg, inAluLatch, inLoadWordDividerMEM, inPcPlus8);
    if (chk_wb) chk("wb_data", outWbData, wd);
    chk("wb_valid", {31'd0, outWbValid}, {31'd0, wr});
    chk("rs_data", outRsData, m_read(inRsAddr, wr, inWriteReg, wd));
    chk("rt_data", outRtData, m_read(inRtAddr, wr, inWriteReg, wd));
    dbg_exp = m_read(inDbgAddr, wr, inWriteReg, wd);
    @(posedge clk);
    if (wr) begin
      m_regs[inWriteReg] = wd;
      m_count = (m_count + 1) % (1 << CW);
    end
    #1;
    chk("dbg_data", outDbgData, dbg_exp);
    chk("write_count", {{(32-CW){1'b0}}, outWriteCount}, m_count);
    @(negedge clk);
  endtask

  initial begin
    m_clear();
    reset = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i));
      cycle(1'b1);
    end

    drive(1'b1, 2'd0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 5'd1, 5'd2, 5'd5);
    cycle(1'b1);
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
    cycle(1'b1);
    chk("reg5_direct", outRsData, 32'h0000_1234);
    chk("count_after_first", {28'd0, outWriteCount}, 32'd1);

    drive(1'b1, 2'd1, 5'd9, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd9, 5'd9);
    #1;
    chk("bypass_rs", outRsData, 32'hDEAD_BEEF);
    chk("bypass_rt", outRtData, 32'hDEAD_BEEF);
    cycle(1'b1);

    drive(1'b1, 2'd2, 5'd0, 32'h0, 32'h0, 32'h0040_0008, 5'd0, 5'd0, 5'd0);
    cycle(1'b1);
    chk("reg0_count_held", {28'd0, outWriteCount}, 32'd2);

    drive(1'b1, 2'd2, 5'd31, 32'h0, 32'h0, 32'h0040_0010, 5'd0, 5'd0, 5'd31);
    cycle(1'b1);
    drive(1'b1, 2'd3, 5'd2, 32'h7, 32'h5, 32'h6, 5'd31, 5'd2, 5'd2);
    cycle(1'b1);
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd31, 5'd2, 5'd2);
    cycle(1'b1);
    chk("reg31_link", outRsData, 32'h0040_0010);
    chk("reg2_rsvd_alu", outRtData, 32'h0000_0007);

    drive(1'b0, 2'bxx, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 5'd5, 5'd9);
    cycle(1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(31));
      drive(1'($urandom_range(1)), 2'($urandom_range(3)), wa,
            $urandom, $urandom, $urandom,
            ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31)),
            ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31)),
            ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31)));
      cycle(1'b1);
    end

    while (m_count != (1 << CW) - 1) begin
      drive(1'b1, 2'd0, 5'd3, $urandom, 32'h0, 32'h0, 5'd3, 5'd4, 5'd3);
      cycle(1'b1);
    end
    drive(1'b1, 2'd0, 5'd4, 32'hCAFE_0004, 32'h0, 32'h0, 5'd4, 5'd3, 5'd4);
    cycle(1'b1);
    chk("count_wrap", {28'd0, outWriteCount}, 32'd0);

    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd3, 5'd4);
    #2;
    reset = 1'b0;
    m_clear();
    #1;
    chk("async_rs_clear", outRsData, 32'd0);
    chk("async_rt_clear", outRtData, 32'd0);
    chk("async_dbg_clear", outDbgData, 32'd0);
    chk("async_count_clear", {28'd0, outWriteCount}, 32'd0);

    drive(1'b1, 2'd0, 5'd7, 32'h0000_0777, 32'h0, 32'h0, 5'd3, 5'd4, 5'd7);
    @(posedge clk);
    #1;
    chk("no_commit_in_reset", {28'd0, outWriteCount}, 32'd0);
    chk("dbg_held_in_reset", outDbgData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1);
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd7, 5'd4, 5'd7);
    cycle(1'b1);
    chk("write_after_release", outRsData, 32'h0000_0777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
